// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_pkg: shared timing, framebuffer geometry and state encoding for the framebuffer arbiter
package vga_fb_pkg;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_WHOLE = 800;
  localparam int V_WHOLE = 525;
  localparam int FB_W = H_VISIBLE / 4;
  localparam int FB_H = V_VISIBLE / 4;
  localparam int FB_CELLS = FB_W * FB_H;
  localparam int AW = 15;
  localparam int DW = 4;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  function automatic logic [AW-1:0] cell_addr(input logic [7:0] row, input logic [7:0] col);
    return (AW'(row) << 7) + (AW'(row) << 5) + AW'(col);
  endfunction
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: RAM bus and writer req/ack port of the framebuffer arbiter
interface vga_fb_arbiter_if;
  import vga_fb_pkg::*;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic wr_ack;
  modport master(output mem_addr, mem_we, mem_wdata, wr_ack, input mem_rdata, wr_req, wr_addr, wr_data);
  modport slave(input mem_addr, mem_we, mem_wdata, wr_ack, output mem_rdata, wr_req, wr_addr, wr_data);
endinterface

// File: rtl/vga_fb_arbiter_addr_gen.sv
// vga_fb_addr_gen: decides fetch slots and the cell address one cell ahead of the beam
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int XBITS = 10,
  parameter int YBITS = 10
) (
  input  logic pix_tick,
  input  logic [XBITS-1:0] x,
  input  logic [YBITS-1:0] y,
  output logic fetch_en,
  output logic [AW-1:0] fetch_addr
);
  logic wrap;
  logic [YBITS-1:0] y_next;
  logic [7:0] row;
  logic [7:0] col;
  // next cell in the line, or column 0 of the following line at the end of blanking
  always_comb begin
    wrap = x == XBITS'(H_WHOLE - 2);
    fetch_en = pix_tick && (wrap || (x[1:0] == 2'd2 && x < XBITS'(H_VISIBLE - 2)));
    y_next = (y == YBITS'(V_WHOLE - 1)) ? '0 : y + 1'b1;
    row = wrap ? 8'(y_next >> 2) : 8'(y >> 2);
    col = wrap ? 8'd0 : 8'(x >> 2) + 8'd1;
    fetch_addr = (row >= 8'(FB_H)) ? '0 : cell_addr(row, col);
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the framebuffer RAM between scan-out prefetch, bulk clear and a writer port
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int XBITS = 10,
  parameter int YBITS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic pix_tick,
  input  logic [XBITS-1:0] x,
  input  logic [YBITS-1:0] y,
  input  logic activevideo,
  vga_fb_arbiter_if.master bus,
  input  logic clr_start,
  input  logic [DW-1:0] clr_color,
  output logic clr_busy,
  output logic [DW-1:0] color_out
);
  state_t state, state_next;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_fill;
  logic fetch_en;
  logic [AW-1:0] fetch_addr;
  logic fetch_q;
  logic [DW-1:0] next_color;
  logic [DW-1:0] cur_color;
  logic load_cur;
  vga_fb_addr_gen #(.XBITS(XBITS), .YBITS(YBITS)) u_addr_gen (
    .pix_tick(pix_tick),
    .x(x),
    .y(y),
    .fetch_en(fetch_en),
    .fetch_addr(fetch_addr)
  );
  assign load_cur = pix_tick && (x[1:0] == 2'd3 || x == XBITS'(H_WHOLE - 1));
  assign clr_busy = state == CLEAR;
  assign color_out = activevideo ? cur_color : '0;
  // fetch owns the RAM when due; otherwise clear, otherwise the writer
  always_comb begin
    state_next = state;
    bus.mem_addr = fetch_addr;
    bus.mem_we = 1'b0;
    bus.mem_wdata = '0;
    bus.wr_ack = 1'b0;
    if (!reset && !fetch_en) begin
      if (state == CLEAR) begin
        bus.mem_addr = clr_cnt;
        bus.mem_we = 1'b1;
        bus.mem_wdata = clr_fill;
        if (clr_cnt == AW'(FB_CELLS - 1)) state_next = IDLE;
      end else if (bus.wr_req) begin
        bus.mem_addr = bus.wr_addr;
        bus.mem_we = bus.wr_addr < AW'(FB_CELLS);
        bus.mem_wdata = bus.wr_data;
        bus.wr_ack = 1'b1;
      end
    end
    if (!reset && state == IDLE && clr_start) state_next = CLEAR;
  end
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : state_next;
  // clear counter, fill colour latch and the two-stage pixel pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt <= '0;
      clr_fill <= '0;
      fetch_q <= 1'b0;
      next_color <= '0;
      cur_color <= '0;
    end else begin
      fetch_q <= fetch_en;
      if (state == IDLE && clr_start) begin
        clr_cnt <= '0;
        clr_fill <= clr_color;
      end else if (state == CLEAR && !fetch_en) clr_cnt <= clr_cnt + 1'b1;
      if (fetch_q) next_color <= bus.mem_rdata;
      if (load_cur) cur_color <= next_color;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of prefetch, writer, clear and reset behaviour
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_tick = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic activevideo = 1'b0;
  logic clr_start = 1'b0;
  logic [3:0] clr_color = '0;
  logic clr_busy;
  logic [3:0] color_out;
  bit run = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int mon_bad = 0;
  int fetch_busy = 0;
  int busy_cnt = 0;
  int ack_busy = 0;
  int wcnt [19200];
  logic [3:0] ram [32768];
  vga_fb_arbiter_if bus();
  vga_fb_arbiter dut (
    .clock(clk),
    .reset(reset),
    .pix_tick(pix_tick),
    .x(x),
    .y(y),
    .activevideo(activevideo),
    .bus(bus),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy(clr_busy),
    .color_out(color_out)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  always @(negedge clk) begin : mon
    int xi, yi, er, ec, ea;
    xi = int'(x);
    yi = int'(y);
    if (pix_tick === 1'b1 && ((xi % 4 == 2 && xi < 638) || xi == 798)) begin
      er = (xi == 798) ? ((yi == 524) ? 0 : (yi + 1) / 4) : yi / 4;
      ec = (xi == 798) ? 0 : xi / 4 + 1;
      ea = (er >= 120) ? 0 : er * 160 + ec;
      if (bus.mem_we !== 1'b0 || bus.mem_addr !== 15'(ea)) mon_bad++;
      if (clr_busy === 1'b1) fetch_busy++;
    end
    if (clr_busy === 1'b1) busy_cnt++;
    if (clr_busy === 1'b1 && bus.wr_ack === 1'b1) ack_busy++;
    if (clr_busy === 1'b1 && bus.mem_we === 1'b1 && bus.mem_addr < 15'd19200) wcnt[bus.mem_addr]++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (run) begin
      if (pix_tick) begin
        if (x == 10'd799) begin
          x = '0;
          y = (y == 10'd524) ? '0 : y + 10'd1;
        end else x = x + 10'd1;
      end
      pix_tick = !pix_tick;
    end else pix_tick = 1'b0;
    activevideo = (x < 10'd640) && (y < 10'd480);
  endtask
  task automatic set_pos(input int xx, input int yy, input bit r);
    @(posedge clk);
    #1;
    x = 10'(xx);
    y = 10'(yy);
    run = r;
    pix_tick = 1'b0;
    activevideo = (x < 10'd640) && (y < 10'd480);
  endtask
  task automatic wr_cell(input int a, input int d);
    set_pos(0, 0, 1'b0);
    bus.wr_req = 1'b1;
    bus.wr_addr = 15'(a);
    bus.wr_data = 4'(d);
    step();
    bus.wr_req = 1'b0;
  endtask
  task automatic test_reset();
    bus.wr_req = 1'b1;
    bus.wr_addr = 15'd5;
    bus.wr_data = 4'd1;
    activevideo = 1'b1;
    for (int i = 0; i < 3; i++) step();
    activevideo = 1'b1;
    @(negedge clk);
    compared++;
    if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
    compared++;
    if (bus.wr_ack !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %b want 0", bus.wr_ack); end
    compared++;
    if (bus.mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    compared++;
    if (color_out !== 4'd0) begin mismatched++; $display("FAIL reset_color: got %0d want 0", color_out); end
    reset = 1'b0;
    bus.wr_req = 1'b0;
  endtask
  task automatic test_frame_wrap();
    wr_cell(0, 11);
    set_pos(796, 524, 1'b1);
    for (int i = 0; i < 20 && !(x == 10'd798 && pix_tick); i++) step();
    @(negedge clk);
    compared++;
    if (bus.mem_addr !== 15'd0 || bus.mem_we !== 1'b0)
      begin mismatched++; $display("FAIL wrap_fetch: got addr %0d we %b want addr 0 we 0", bus.mem_addr, bus.mem_we); end
    for (int i = 0; i < 20 && !(x == 10'd0 && y == 10'd0); i++) step();
    @(negedge clk);
    compared++;
    if (color_out !== 4'd11) begin mismatched++; $display("FAIL wrap_color: got %0d want 11 at x=%0d y=%0d", color_out, x, y); end
  endtask
  task automatic test_display();
    int e;
    wr_cell(0, 5);
    wr_cell(1, 9);
    wr_cell(2, 4);
    set_pos(796, 524, 1'b1);
    for (int i = 0; i < 8000 && y != 10'd4; i++) begin
      step();
      @(negedge clk);
      if (y < 10'd4 && x < 10'd12) begin
        e = (x < 10'd4) ? 5 : (x < 10'd8) ? 9 : 4;
        compared++;
        if (color_out !== 4'(e)) begin mismatched++; $display("FAIL display x=%0d y=%0d: got %0d want %0d", x, y, color_out, e); end
      end
      if (y == 10'd0 && x == 10'd640) begin
        compared++;
        if (color_out !== 4'd0) begin mismatched++; $display("FAIL blank x=640: got %0d want 0", color_out); end
      end
    end
    compared++;
    if (y !== 10'd4) begin mismatched++; $display("FAIL display_timeout: got y=%0d want 4", y); end
  endtask
  task automatic test_writer();
    wr_cell(161, 2);
    set_pos(1, 3, 1'b1);
    for (int i = 0; i < 10 && !(x == 10'd2 && pix_tick); i++) step();
    bus.wr_req = 1'b1;
    bus.wr_addr = 15'd161;
    bus.wr_data = 4'd7;
    @(negedge clk);
    compared++;
    if (bus.wr_ack !== 1'b0 || bus.mem_we !== 1'b0)
      begin mismatched++; $display("FAIL wr_collide: got ack %b we %b want 0 0", bus.wr_ack, bus.mem_we); end
    step();
    @(negedge clk);
    compared++;
    if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd161 || bus.mem_wdata !== 4'd7)
      begin mismatched++; $display("FAIL wr_retry: got ack %b we %b addr %0d data %0d want 1 1 161 7", bus.wr_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step();
    bus.wr_req = 1'b0;
    for (int i = 0; i < 9000 && !(y == 10'd8 && x == 10'd0); i++) begin
      step();
      @(negedge clk);
      if (y >= 10'd4 && y < 10'd8 && x >= 10'd4 && x < 10'd8) begin
        compared++;
        if (color_out !== 4'd7) begin mismatched++; $display("FAIL wr_display x=%0d y=%0d: got %0d want 7", x, y, color_out); end
      end
    end
    set_pos(0, 0, 1'b0);
    bus.wr_req = 1'b1;
    bus.wr_addr = 15'd19300;
    bus.wr_data = 4'd5;
    @(negedge clk);
    compared++;
    if (bus.wr_ack !== 1'b1 || bus.mem_we !== 1'b0)
      begin mismatched++; $display("FAIL wr_range: got ack %b we %b want 1 0", bus.wr_ack, bus.mem_we); end
    step();
    bus.wr_req = 1'b0;
  endtask
  task automatic test_clear();
    int b0, f0, a0, bad, n;
    bit acked;
    set_pos(700, 524, 1'b1);
    b0 = busy_cnt;
    f0 = fetch_busy;
    a0 = ack_busy;
    clr_color = 4'd3;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    clr_color = 4'd0;
    @(negedge clk);
    compared++;
    if (clr_busy !== 1'b1) begin mismatched++; $display("FAIL clr_start: got busy %b want 1", clr_busy); end
    for (int t = 0; t < 30000 && clr_busy === 1'b1; t++) begin
      step();
      if (t == 100) begin bus.wr_req = 1'b1; bus.wr_addr = 15'd500; bus.wr_data = 4'd6; end
      clr_start = (t == 200);
      clr_color = (t == 200) ? 4'd9 : 4'd0;
      @(negedge clk);
    end
    compared++;
    if (clr_busy !== 1'b0) begin mismatched++; $display("FAIL clr_done: got busy %b want 0", clr_busy); end
    compared++;
    if (busy_cnt - b0 !== 19200 + fetch_busy - f0)
      begin mismatched++; $display("FAIL clr_length: got %0d busy clocks want %0d", busy_cnt - b0, 19200 + fetch_busy - f0); end
    compared++;
    if (ack_busy - a0 !== 0) begin mismatched++; $display("FAIL clr_ack_busy: got %0d acks want 0", ack_busy - a0); end
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      if (bus.wr_ack === 1'b1) acked = 1'b1;
      else begin step(); @(negedge clk); end
    end
    compared++;
    if (!acked || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd500)
      begin mismatched++; $display("FAIL clr_wr_after: got ack %b we %b addr %0d want 1 1 500", acked, bus.mem_we, bus.mem_addr); end
    step();
    bus.wr_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 19200; i++) if (ram[i] !== ((i == 500) ? 4'd6 : 4'd3)) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL clr_ram: got %0d wrong cells want 0", bad); end
    bad = 0;
    for (int i = 0; i < 19200; i++) if (wcnt[i] !== 1) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL clr_once: got %0d cells not written once want 0", bad); end
    compared++;
    if (mon_bad !== 0) begin mismatched++; $display("FAIL fetch_slots: got %0d bad fetch clocks want 0", mon_bad); end
    set_pos(796, 524, 1'b1);
    bad = 0;
    n = 0;
    for (int i = 0; i < 4000 && !(y == 10'd2 && x == 10'd0); i++) begin
      step();
      @(negedge clk);
      if (activevideo && y < 10'd2) begin
        n++;
        if (color_out !== 4'd3) bad++;
      end
    end
    compared++;
    if (bad !== 0 || n !== 2560) begin mismatched++; $display("FAIL clr_display: got %0d bad of %0d want 0 of 2560", bad, n); end
  endtask
  task automatic test_reset_mid_clear();
    int bad;
    set_pos(0, 0, 1'b0);
    clr_color = 4'd12;
    clr_start = 1'b1;
    bus.wr_req = 1'b1;
    bus.wr_addr = 15'd1500;
    bus.wr_data = 4'd9;
    @(negedge clk);
    compared++;
    if (bus.wr_ack !== 1'b1 || clr_busy !== 1'b0)
      begin mismatched++; $display("FAIL same_cycle: got ack %b busy %b want 1 0", bus.wr_ack, clr_busy); end
    step();
    clr_start = 1'b0;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    @(negedge clk);
    compared++;
    if (clr_busy !== 1'b1 || bus.mem_addr !== 15'd1000)
      begin mismatched++; $display("FAIL mid_clear: got busy %b addr %0d want 1 1000", clr_busy, bus.mem_addr); end
    reset = 1'b1;
    step();
    @(negedge clk);
    compared++;
    if (clr_busy !== 1'b0 || color_out !== 4'd0 || bus.mem_we !== 1'b0)
      begin mismatched++; $display("FAIL clr_abort: got busy %b color %0d we %b want 0 0 0", clr_busy, color_out, bus.mem_we); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) if (ram[i] !== 4'd12) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL abort_low: got %0d wrong cells want 0", bad); end
    bad = 0;
    for (int i = 1000; i < 19200; i++) if (ram[i] !== ((i == 1500) ? 4'd9 : 4'd3)) bad++;
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL abort_high: got %0d changed cells want 0", bad); end
  endtask
  initial begin
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_frame_wrap();
    test_display();
    test_writer();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between the VGA scan-out path and game-logic writers.
- Framebuffer is 160x120 cells of DW-bit colour; each cell covers a 4x4 block of the 640x480 display.
- Sits between the sync timer (x, y, activevideo, pixel tick) and the colour DAC pins.
- Prefetches cells ahead of the beam, services a writer req/ack port, and runs a bulk clear engine in the leftover memory slots.

Parameters:
- XBITS, 10, width of x
- YBITS, 10, width of y
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines
- H_WHOLE, 800, pixels per line incl. blanking
- V_WHOLE, 525, lines per frame incl. blanking
- FB_W, 160, framebuffer columns
- FB_H, 120, framebuffer rows
- AW, 15, RAM address width
- DW, 4, colour width

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- pix_tick  in  1  one-clock strobe; x/y advance on the clock edge ending a pix_tick cycle
- x  in  XBITS  current column from the sync timer
- y  in  YBITS  current line from the sync timer
- activevideo  in  1  beam is in the visible area
- mem_addr  out  AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one clock after the address
- wr_req  in  1  writer request; held with wr_addr/wr_data until ack
- wr_addr  in  AW  writer cell address (row*FB_W+col)
- wr_data  in  DW  writer colour
- wr_ack  out  1  one-clock pulse in the cycle the write hits RAM
- clr_start  in  1  pulse: start a full-framebuffer fill
- clr_color  in  DW  fill colour, sampled at clr_start
- clr_busy  out  1  fill in progress
- color_out  out  DW  pixel colour; 0 when activevideo=0

Behaviour:
- Reset values:
  - cur_color, next_color, clr_cnt, state: 0 / IDLE.
  - clr_busy, wr_ack, mem_we: 0.
  - color_out: 0.
- Fetch slot:
  - A fetch occurs in a clock where pix_tick=1 and either x[1:0]==2 with x<H_VISIBLE-2, or x==H_WHOLE-2.
  - Target cell for the first case: column (x>>2)+1, row y>>2.
  - Target cell for the x==H_WHOLE-2 case: column 0 of the next line. Row is (y+1)>>2, or 0 when y==V_WHOLE-1.
  - Rows at or above FB_H (blanking) still issue a fetch; the address is clamped to 0 and the data is ignored.
- Fetch timing:
  - mem_addr = row*FB_W + col, computed as (row<<7)+(row<<5)+col; mem_we=0.
  - next_color <= mem_rdata one clock later.
  - cur_color <= next_color on a pix_tick where x[1:0]==3 or x==H_WHOLE-1.
  - color_out = activevideo ? cur_color : 0.
  - Pixel colour therefore aligns with x, with no extra latency.
- Priority:
  - fetch > clear > writer.
  - Fetch occupies at most 1 of every 8 clocks, so clear and writer progress is guaranteed.
- State machine IDLE / CLEAR:
  - IDLE→CLEAR on clr_start: latch clr_color, clr_cnt=0, clr_busy=1.
  - In CLEAR, each non-fetch clock writes clr_cnt with the latched colour and increments clr_cnt.
  - After the write to FB_W*FB_H-1 (19199): →IDLE, clr_busy=0 on the next clock.
  - clr_start while in CLEAR is ignored.
- Writer:
  - In IDLE, on a non-fetch clock with wr_req=1: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1 in the same clock.
  - In CLEAR, wr_req is never acked; it waits until the clear completes.
  - A writer collided by a fetch is acked on the next clock.
  - wr_addr ≥ FB_W*FB_H is acked but not written (mem_we=0).
- Same-cycle events:
  - clr_start and wr_req in the same IDLE non-fetch clock: the write is acked in that clock, and CLEAR begins the next clock.
- Reset mid-clear: aborts the clear immediately; partially filled RAM content is left as-is.
- No combinational path from wr_req to color_out.

Decomposition:
- Package vga_fb_pkg:
  - timing constants H_VISIBLE, V_VISIBLE, H_WHOLE, V_WHOLE.
  - FB_W, FB_H, FB_CELLS=19200, AW, DW.
  - state encoding IDLE=0, CLEAR=1.
- Sub-module vga_fb_addr_gen: combinational (x, y) → fetch_en and fetch address, including line/frame wrap and row clamp.

Test Plan:
- Preload RAM cell 0 with 5 and cell 1 with 9; run the timer → color_out=5 for x=0..3, y=0..3, and 9 for x=4..7; 0 at x=640.
- wr_req held with wr_addr=161, wr_data=7; request starts in a fetch clock (x=2, pix_tick) → no ack that clock, wr_ack next clock. Cell 161 reads 7 and displays at x=4..7, y=4..7.
- clr_start with clr_color=3 → clr_busy high for ≥19200 clocks. Every cell 0..19199 is written with 3 exactly once, no fetch is missed, and the frame displays all 3.
- wr_req asserted during CLEAR → wr_ack stays 0 until clr_busy falls; then the write lands and overrides 3.
- reset asserted at clr_cnt=1000 → clr_busy=0, color_out=0, and cells ≥1000 are unchanged.
- Frame wrap, y=524, x=798, pix_tick → fetch address 0; at y=0, x=0 color_out shows cell 0.
